// File: rtl/kugelblitz_patch_ctrl.sv
// Byte-rewrite controller for one AXI-stream port: a shadow/active rule table with
// frame-boundary commits, one registered patch stage and a patched-frame counter.
module kugelblitz_patch_ctrl #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1,
    parameter int RULE_COUNT   = 4,
    parameter int IDX_WIDTH    = $clog2(RULE_COUNT),
    parameter int OFFSET_WIDTH = 11,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]    cfg_wr_idx,
    input  logic [OFFSET_WIDTH-1:0] cfg_wr_offset,
    input  logic [7:0]              cfg_wr_value,
    input  logic                    cfg_wr_enable,
    input  logic                    cfg_commit,
    output logic                    cfg_pending,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic [CNT_WIDTH-1:0]    stat_frames_patched,
    input  logic                    stat_clear
);

    localparam int LANE_WIDTH = $clog2(KEEP_WIDTH);
    // One spare bit so the saturated beat count lies above every reachable target beat.
    localparam int BEAT_WIDTH = OFFSET_WIDTH - LANE_WIDTH + 1;
    localparam logic [BEAT_WIDTH-1:0] BEAT_MAX = '1;

    typedef struct packed {
        logic                    en;
        logic [OFFSET_WIDTH-1:0] off;
        logic [7:0]              val;
    } rule_t;

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    rule_t [RULE_COUNT-1:0] shadow_q, shadow_d, active_q, active_d;
    state_t                 state_q, state_d;
    logic [BEAT_WIDTH-1:0]  beat_q, beat_d;
    logic                   pending_q, pending_d;
    logic                   frame_hit_q, frame_hit_d;
    logic [CNT_WIDTH-1:0]   stat_q, stat_d;
    logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0]  m_tkeep_q, m_tkeep_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic                   m_tlast_q, m_tlast_d;
    logic [USER_WIDTH-1:0]  m_tuser_q, m_tuser_d;

    logic [RULE_COUNT-1:0]  rule_beat_match;
    logic [DATA_WIDTH-1:0]  patched_data;
    logic [KEEP_WIDTH-1:0]  lane_hit;
    logic                   beat_hit;
    logic                   in_hs;
    logic                   tlast_hs;
    logic                   copy_now;

    // Later rules overwrite earlier ones, so the highest enabled index wins a shared byte.
    function automatic logic [8:0] patch_lane(
        input logic [LANE_WIDTH-1:0] lane,
        input logic [7:0]            din,
        input logic                  keep,
        input logic [RULE_COUNT-1:0] match,
        input rule_t [RULE_COUNT-1:0] rules
    );
        logic [8:0] res;
        res = {1'b0, din};
        for (int r = 0; r < RULE_COUNT; r++) begin
            if (keep && match[r] && rules[r].off[LANE_WIDTH-1:0] == lane) begin
                res = {1'b1, rules[r].val};
            end
        end
        return res;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < RULE_COUNT; gi++) begin : g_rule
            assign rule_beat_match[gi] = active_q[gi].en &&
                (beat_q == {1'b0, active_q[gi].off[OFFSET_WIDTH-1:LANE_WIDTH]});
        end
        for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
            logic [8:0] lane_res;
            assign lane_res = patch_lane(LANE_WIDTH'(gi), s_axis_tdata[gi*8 +: 8],
                                         s_axis_tkeep[gi], rule_beat_match, active_q);
            assign patched_data[gi*8 +: 8] = lane_res[7:0];
            assign lane_hit[gi]            = lane_res[8];
        end
    endgenerate

    assign beat_hit      = |lane_hit;
    assign s_axis_tready = m_axis_tready || !m_tvalid_q;
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign tlast_hs      = in_hs && s_axis_tlast;
    assign copy_now      = pending_q && (tlast_hs || (state_q == IDLE && !in_hs));

    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        state_d     = state_q;
        beat_d      = beat_q;
        pending_d   = pending_q;
        frame_hit_d = frame_hit_q;
        stat_d      = stat_q;
        m_tdata_d   = m_tdata_q;
        m_tkeep_d   = m_tkeep_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_tuser_d   = m_tuser_q;

        if (in_hs) begin
            m_tdata_d  = patched_data;
            m_tkeep_d  = s_axis_tkeep;
            m_tvalid_d = 1'b1;
            m_tlast_d  = s_axis_tlast;
            m_tuser_d  = s_axis_tuser;
            if (s_axis_tlast) begin
                beat_d      = '0;
                frame_hit_d = 1'b0;
            end else begin
                if (beat_q != BEAT_MAX) begin
                    beat_d = beat_q + 1'b1;
                end
                frame_hit_d = frame_hit_q || beat_hit;
            end
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE:    if (in_hs && !s_axis_tlast) state_d = FRAME;
            FRAME:   if (tlast_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (stat_clear) begin
            stat_d = '0;
        end else if (tlast_hs && (frame_hit_q || beat_hit) && stat_q != '1) begin
            stat_d = stat_q + 1'b1;
        end

        // The copy takes the shadow as it stood before this cycle's write.
        if (copy_now) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (cfg_commit) begin
            pending_d = 1'b1;
        end

        if (cfg_wr_en) begin
            shadow_d[cfg_wr_idx] = {cfg_wr_enable, cfg_wr_offset, cfg_wr_value};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            active_q    <= '0;
            state_q     <= IDLE;
            beat_q      <= '0;
            pending_q   <= 1'b0;
            frame_hit_q <= 1'b0;
            stat_q      <= '0;
            m_tdata_q   <= '0;
            m_tkeep_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tuser_q   <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            state_q     <= state_d;
            beat_q      <= beat_d;
            pending_q   <= pending_d;
            frame_hit_q <= frame_hit_d;
            stat_q      <= stat_d;
            m_tdata_q   <= m_tdata_d;
            m_tkeep_q   <= m_tkeep_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tuser_q   <= m_tuser_d;
        end
    end

    assign cfg_pending         = pending_q;
    assign stat_frames_patched = stat_q;
    assign m_axis_tdata        = m_tdata_q;
    assign m_axis_tkeep        = m_tkeep_q;
    assign m_axis_tvalid       = m_tvalid_q;
    assign m_axis_tlast        = m_tlast_q;
    assign m_axis_tuser        = m_tuser_q;

endmodule
